// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and constants for the memory-stage data-bus adapter
// Contents: funct3 load/store encodings, 2-bit FSM state encoding, byte-enable
// patterns, and helpers that classify access size and alignment.
package mem_if_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Unlisted funct3 codes fall through to word accesses.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: f3_size = SZ_BYTE;
      F3_LH, F3_LHU: f3_size = SZ_HALF;
      default:       f3_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - lane select and sign/zero extension of a loaded bus word
// Ports: rdata_i (raw bus word), offset_i (byte offset within word),
//        funct3_i (load size/sign), data_o (extended 32-bit result).
module load_formatter
  import mem_if_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[7:0];
    case (offset_i)
      2'd0: byte_lane = rdata_i[7:0];
      2'd1: byte_lane = rdata_i[15:8];
      2'd2: byte_lane = rdata_i[23:16];
      2'd3: byte_lane = rdata_i[31:24];
      default: byte_lane = rdata_i[7:0];
    endcase
  end

  // Halves are always aligned here, so only offset bit 1 picks the lane.
  assign half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  data_o = {24'h0, byte_lane};
      F3_LH:   data_o = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  data_o = {16'h0, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - MEM-stage adapter running single-outstanding req/ack data-bus cycles
// Ports: clk/rst; datapath request (i_mem_read_M, i_mem_write_M, i_addr_M,
//        i_write_data_M, i_funct3_MEM); o_read_data_M load result; o_stall_mem
//        hazard hold; o_misaligned / o_bus_fault status pulses; bus master side
//        o_bus_cyc/we/addr/wdata/sel with i_bus_ack/i_bus_rdata returns.
module data_mem_if
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_read_M,
  input  logic                  i_mem_write_M,
  input  logic [DATA_WIDTH-1:0] i_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic [2:0]            i_funct3_MEM,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_stall_mem,
  output logic                  o_misaligned,
  output logic                  o_bus_fault,
  output logic                  o_bus_cyc,
  output logic                  o_bus_we,
  output logic [DATA_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  output logic [3:0]            o_bus_sel,
  input  logic                  i_bus_ack,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q;
  logic                  cyc_q, we_q, misaligned_q, fault_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [3:0]            sel_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;

  logic                  req, misaligned, timeout;
  size_t                 req_size;
  logic [3:0]            req_sel;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [31:0]           fmt_data;

  assign req        = i_mem_read_M | i_mem_write_M;
  assign req_size   = f3_size(i_funct3_MEM);
  assign misaligned = is_misaligned(req_size, i_addr_M[1:0]);
  // Ack is checked first wherever this is used, so ack wins a tie.
  assign timeout    = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    req_sel   = SEL_WORD;
    req_wdata = i_write_data_M;
    case (req_size)
      SZ_BYTE: begin
        req_sel   = SEL_BYTE << i_addr_M[1:0];
        req_wdata = {4{i_write_data_M[7:0]}};
      end
      SZ_HALF: begin
        req_sel   = SEL_HALF << i_addr_M[1:0];
        req_wdata = {2{i_write_data_M[15:0]}};
      end
      default: begin
        req_sel   = SEL_WORD;
        req_wdata = i_write_data_M;
      end
    endcase
  end

  load_formatter u_load_formatter (
    .rdata_i  (i_bus_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (fmt_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req && !misaligned) state_d = ST_BUSY;
      ST_BUSY: if (i_bus_ack || timeout) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the stall must assert in the request cycle itself so the
  // pipeline never advances past an access that is about to go on the bus.
  always_comb begin
    o_stall_mem = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: o_stall_mem = req && !misaligned;
        ST_BUSY: o_stall_mem = 1'b1;
        default: o_stall_mem = 1'b0;
      endcase
    end
  end

  // Request latch, bus registers, timeout counter and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (misaligned) begin
              misaligned_q <= 1'b1;
              rdata_q      <= '0;
            end else begin
              cyc_q   <= 1'b1;
              we_q    <= i_mem_write_M;
              addr_q  <= {i_addr_M[DATA_WIDTH-1:2], 2'b00};
              wdata_q <= req_wdata;
              sel_q   <= req_sel;
              f3_q    <= i_funct3_MEM;
              off_q   <= i_addr_M[1:0];
              cnt_q   <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (i_bus_ack) begin
            cyc_q <= 1'b0;
            if (!we_q) rdata_q <= fmt_data;
          end else if (timeout) begin
            cyc_q   <= 1'b0;
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_read_data_M = rdata_q;
  assign o_misaligned  = misaligned_q;
  assign o_bus_fault   = fault_q;
  assign o_bus_cyc     = cyc_q;
  assign o_bus_we      = we_q;
  assign o_bus_addr    = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_bus_sel     = sel_q;

endmodule

// File: tb/tb_data_mem_if.sv
// tb/tb_data_mem_if.sv - directed self-checking bench for data_mem_if
module tb_data_mem_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata_in;
  logic [2:0]  f3;
  logic [31:0] read_data;
  logic        stall, misal, fault, cyc, we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        ack;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  data_mem_if #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_mem_read_M   (mem_read),
    .i_mem_write_M  (mem_write),
    .i_addr_M       (addr),
    .i_write_data_M (wdata_in),
    .i_funct3_MEM   (f3),
    .o_read_data_M  (read_data),
    .o_stall_mem    (stall),
    .o_misaligned   (misal),
    .o_bus_fault    (fault),
    .o_bus_cyc      (cyc),
    .o_bus_we       (we),
    .o_bus_addr     (bus_addr),
    .o_bus_wdata    (bus_wdata),
    .o_bus_sel      (bus_sel),
    .i_bus_ack      (ack),
    .i_bus_rdata    (rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drop_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wdata_in = '0; f3 = 3'b010; ack = 1'b0; rdata = '0;
    tick(); tick();
    check("rst_rdata", read_data, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_cyc",   {31'h0, cyc}, 32'h0);
    check("rst_misal", {31'h0, misal}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_sel",   {28'h0, bus_sel}, 32'h0);
    rst = 1'b0;
    tick();

    // LW 0x100, ack in second BUSY cycle: stall for three cycles
    mem_read = 1'b1; addr = 32'h0000_0100; f3 = 3'b010;
    #1;
    check("lw_stall_req", {31'h0, stall}, 32'h1);
    check("lw_cyc_req",   {31'h0, cyc}, 32'h0);
    tick();
    check("lw_cyc",   {31'h0, cyc}, 32'h1);
    check("lw_addr",  bus_addr, 32'h0000_0100);
    check("lw_sel",   {28'h0, bus_sel}, 32'hF);
    check("lw_we",    {31'h0, we}, 32'h0);
    check("lw_stall1", {31'h0, stall}, 32'h1);
    tick();
    check("lw_stall2", {31'h0, stall}, 32'h1);
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0; drop_req();
    check("lw_done_cyc",   {31'h0, cyc}, 32'h0);
    check("lw_done_stall", {31'h0, stall}, 32'h0);
    check("lw_data",       read_data, 32'hDEAD_BEEF);
    tick();

    // LB 0x103, minimum latency ack
    mem_read = 1'b1; addr = 32'h0000_0103; f3 = 3'b000;
    tick();
    check("lb_sel",  {28'h0, bus_sel}, 32'h8);
    check("lb_addr", bus_addr, 32'h0000_0100);
    ack = 1'b1; rdata = 32'h80FF_FF7F;
    tick();
    ack = 1'b0; drop_req();
    check("lb_data",  read_data, 32'hFFFF_FF80);
    check("lb_stall", {31'h0, stall}, 32'h0);
    tick();

    // LBU, same address and data
    mem_read = 1'b1; addr = 32'h0000_0103; f3 = 3'b100;
    tick();
    ack = 1'b1; rdata = 32'h80FF_FF7F;
    tick();
    ack = 1'b0; drop_req();
    check("lbu_data", read_data, 32'h0000_0080);
    tick();

    // SH 0x202 with read also high: write wins, read data untouched
    mem_read = 1'b1; mem_write = 1'b1; addr = 32'h0000_0202;
    wdata_in = 32'h1234_ABCD; f3 = 3'b001;
    tick();
    check("sh_we",    {31'h0, we}, 32'h1);
    check("sh_sel",   {28'h0, bus_sel}, 32'hC);
    check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    check("sh_addr",  bus_addr, 32'h0000_0200);
    ack = 1'b1; rdata = 32'h5555_5555;
    tick();
    ack = 1'b0; drop_req();
    check("sh_data_kept", read_data, 32'h0000_0080);
    tick();

    // LW with no ack: 4 cycles of cyc, then fault
    mem_read = 1'b1; addr = 32'h0000_0300; f3 = 3'b010;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("to_cyc%0d", i), {31'h0, cyc}, 32'h1);
    end
    tick();
    drop_req();
    check("to_cyc_off", {31'h0, cyc}, 32'h0);
    check("to_fault",   {31'h0, fault}, 32'h1);
    check("to_stall",   {31'h0, stall}, 32'h0);
    check("to_data",    read_data, 32'h0);
    tick();
    check("to_fault_end", {31'h0, fault}, 32'h0);

    // LW to load a non-zero value before misaligned test
    mem_read = 1'b1; addr = 32'h0000_0104; f3 = 3'b010;
    tick();
    ack = 1'b1; rdata = 32'h1122_3344;
    tick();
    ack = 1'b0; drop_req();
    check("lw2_data", read_data, 32'h1122_3344);
    tick();

    // LW 0x106: misaligned, dropped
    mem_read = 1'b1; addr = 32'h0000_0106; f3 = 3'b010;
    #1;
    check("mis_stall", {31'h0, stall}, 32'h0);
    tick();
    drop_req();
    check("mis_pulse", {31'h0, misal}, 32'h1);
    check("mis_cyc",   {31'h0, cyc}, 32'h0);
    check("mis_data",  read_data, 32'h0);
    tick();
    check("mis_pulse_end", {31'h0, misal}, 32'h0);

    // LHU 0x105: misaligned half
    mem_read = 1'b1; addr = 32'h0000_0105; f3 = 3'b101;
    tick();
    drop_req();
    check("mish_pulse", {31'h0, misal}, 32'h1);
    check("mish_cyc",   {31'h0, cyc}, 32'h0);
    tick();

    // Reset during BUSY, then a late ack
    mem_read = 1'b1; addr = 32'h0000_0400; f3 = 3'b010;
    tick();
    check("rb_cyc", {31'h0, cyc}, 32'h1);
    rst = 1'b1; drop_req();
    tick();
    check("rb_cyc_off", {31'h0, cyc}, 32'h0);
    check("rb_stall",   {31'h0, stall}, 32'h0);
    rst = 1'b0; ack = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    ack = 1'b0;
    check("rb_late_cyc",   {31'h0, cyc}, 32'h0);
    check("rb_late_stall", {31'h0, stall}, 32'h0);
    check("rb_late_data",  read_data, 32'h0);
    check("rb_late_fault", {31'h0, fault}, 32'h0);
    check("rb_late_sel",   {28'h0, bus_sel}, 32'h0);
    check("rb_late_addr",  bus_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_if.md
Name: data_mem_if

Overview:
Memory-stage data-bus adapter sitting directly downstream of the core datapath's MEM outputs.
- Takes address, store data, write enable and funct3 from the datapath, plus a read enable from the controller.
- Runs a single-outstanding req/ack transaction on the external data bus, with byte-lane formatting for stores and sign/zero extension for loads.
- Returns formatted load data to the datapath's read-data input.
- Drives a stall request into the hazard path while a transaction is in flight.

Parameters:
DATA_WIDTH, 32, data and address width (fixed 32 for RV32; other values unsupported).
TIMEOUT_CYCLES, 255, number of BUSY cycles without ack before a bus fault is declared (1..255).

Ports:
clk  in  1  core clock.
rst  in  1  reset: synchronous, active-high, sampled on the rising edge of clk.
i_mem_read_M  in  1  load request in MEM stage.
i_mem_write_M  in  1  store request in MEM stage.
i_addr_M  in  32  byte address.
i_write_data_M  in  32  raw store data (rs2).
i_funct3_MEM  in  3  access size/sign.
o_read_data_M  out  32  formatted load data, registered.
o_stall_mem  out  1  hold IF..MEM while high.
o_misaligned  out  1  one-cycle pulse, misaligned access dropped.
o_bus_fault  out  1  one-cycle pulse, ack timeout.
o_bus_cyc  out  1  transaction valid.
o_bus_we  out  1  1 = write.
o_bus_addr  out  32  word address, bits [1:0] = 0.
o_bus_wdata  out  32  lane-replicated store data.
o_bus_sel  out  4  byte enables.
i_bus_ack  in  1  transaction complete, single cycle.
i_bus_rdata  in  32  read word, valid with ack.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- funct3 encoding:
  - 000 byte signed
  - 001 half signed
  - 010 word
  - 100 byte unsigned
  - 101 half unsigned
  - any other value is treated as word.
- Read and write both high: treated as write; the read is ignored.
- Alignment: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - No bus cycle and no stall.
  - o_misaligned pulses for 1 cycle.
  - o_read_data_M is loaded with 0 on the next edge.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - An aligned request drives o_stall_mem=1 combinationally in the same cycle.
  - On that edge: latch addr/sel/wdata/we/funct3/offset, set o_bus_cyc=1, go BUSY.
  - An ack seen in IDLE is ignored.
- BUSY:
  - o_stall_mem=1; bus outputs held stable; counter increments each cycle.
  - On i_bus_ack: capture formatted i_bus_rdata into o_read_data_M (loads only; stores leave it unchanged), clear cyc, go DONE.
  - Counter reaching TIMEOUT_CYCLES without ack: clear cyc, o_bus_fault pulse, o_read_data_M=0, go DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - o_stall_mem=0 for exactly one cycle so the pipeline advances; request inputs are ignored.
  - Then go IDLE.
- Latency: request in cycle N with ack in N+1 gives DONE in N+2. Minimum 2 stall cycles per aligned access.
- Store formatting:
  - Byte: sel = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - Half: sel = 0011 << addr[1:0]; wdata = half replicated ×2.
  - Word: sel = 1111.
- Load formatting:
  - Select lane by latched offset.
  - Sign-extend for 000/001; zero-extend for 100/101.
- Reset mid-transaction: cyc drops at that edge, state returns to IDLE, the latched request is discarded, and a late ack is ignored.

Decomposition:
- Shared package `mem_if_pkg`:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
  - FSM state encoding (2-bit)
  - byte-enable constants.
- One combinational sub-module, `load_formatter`: inputs rdata, offset, funct3; output extended 32-bit word. Reused by any future I-cache-less load path.

Test Plan:
- LW addr 0x0000_0100, ack 2 cycles after cyc, rdata 0xDEADBEEF -> bus_addr 0x100, sel 1111, stall high 3 cycles, o_read_data_M=0xDEADBEEF.
- LB addr 0x0000_0103, rdata 0x80FF_FF7F -> sel 1000, o_read_data_M=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- SH addr 0x0000_0202, write data 0x1234_ABCD -> we=1, sel 1100, wdata 0xABCD_ABCD, o_read_data_M unchanged.
- LW addr 0x0000_0106 -> no cyc, no stall, o_misaligned pulse 1 cycle, o_read_data_M=0.
- LW with ack never asserted, TIMEOUT_CYCLES=4 -> cyc high 4 cycles, o_bus_fault pulse, data 0, stall released after DONE.
- rst asserted during BUSY, ack arrives 1 cycle later -> cyc=0 and stall=0 after that edge, ack ignored, all outputs 0.
